bcd_count_ctrl: RTL

Synchronous command-driven controller for a multi-digit BCD up/down count register built from decade stages. Accepts CLEAR, UP, DOWN and LOAD commands over a valid/ready handshake. Sequences carry/borrow ripple one decade per clock and reports completion, wrap and terminal-count status. Sits between the control/host logic and the display/compare datapath that consumes the BCD count.

---
 rtl/bcd_count_ctrl_pkg.sv | 27 ++
 rtl/bcd_count_ctrl_digit_step.sv | 42 ++++
 rtl/bcd_count_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_count_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bcd_count_ctrl_pkg
//   Shared definitions for the BCD count controller:
//     - CMD_OP encodings (OP_CLEAR, OP_UP, OP_DOWN, OP_LOAD)
//     - controller state enum (ST_IDLE, ST_RIPPLE)
//     - BCD_MAX, the largest legal decade value
//     - bcd_digit_ok(), legality check for one nibble
// ---------------------------------------------------------------------------
package bcd_count_ctrl_pkg;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam logic [3:0] BCD_MAX  = 4'd9;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RIPPLE = 1'b1
    } state_t;

    function automatic logic bcd_digit_ok(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_digit_step.sv
// ---------------------------------------------------------------------------
// bcd_digit_step
//   Combinational single-decade step. Increments or decrements one BCD
//   digit and flags the carry (9 -> 0 on up) or borrow (0 -> 9 on down).
//
// Ports
//   digit   in   current decade value (0..9)
//   up      in   1 = increment, 0 = decrement
//   result  out  stepped decade value
//   carry   out  carry (up) or borrow (down) out of this decade
// ---------------------------------------------------------------------------
module bcd_digit_step
    import bcd_count_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       up,
    output logic [3:0] result,
    output logic       carry
);

    always_comb begin
        result = digit;
        carry  = 1'b0;
        if (up) begin
            // >= rather than == so a corrupted nibble still lands on a legal digit
            if (digit >= BCD_MAX) begin
                result = 4'd0;
                carry  = 1'b1;
            end else begin
                result = digit + 4'd1;
            end
        end else begin
            if (digit == 4'd0) begin
                result = BCD_MAX;
                carry  = 1'b1;
            end else begin
                result = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_count_ctrl
//   Command-driven controller for a DIGITS-decade BCD up/down count register.
//   CLEAR and LOAD complete at the accept edge. UP/DOWN step digit 0 at the
//   accept edge; a carry/borrow then ripples one decade per clock through
//   the RIPPLE state, so intermediate Q values are visible while BUSY is high.
//
// Configuration macro
//   BCD_COUNT_CTRL_SAT_EN  when defined, UP at all-9s and DOWN at all-0s
//                          saturate (Q held, OVF with DONE) instead of
//                          wrapping through the full range.
//
// Ports
//   CLK        in   rising-edge clock
//   MR         in   synchronous active-high master reset, highest priority
//   CMD_VALID  in   command present
//   CMD_READY  out  controller idle and able to accept
//   CMD_OP     in   00 CLEAR, 01 UP, 10 DOWN, 11 LOAD
//   D          in   BCD load value, digit 0 in [3:0]
//   Q          out  current BCD count
//   BUSY       out  carry/borrow ripple in progress
//   DONE       out  one-cycle completion pulse
//   OVF        out  with DONE: full-range wrap or saturation
//   ERR        out  with DONE: LOAD rejected (non-BCD nibble)
//   TCU        out  active-low, 0 when every digit is 9
//   TCD        out  active-low, 0 when every digit is 0
// ---------------------------------------------------------------------------
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
)
(
    input  logic                  CLK,
    input  logic                  MR,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_OP,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF,
    output logic                  ERR,
    output logic                  TCU,
    output logic                  TCD
);

    localparam int QW    = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

`ifdef BCD_COUNT_CTRL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Whole-register decodes
    // ------------------------------------------------------------------
    function automatic logic all_nines(input logic [QW-1:0] q);
        logic r;
        r = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (q[k*4 +: 4] != BCD_MAX) r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic all_zeros(input logic [QW-1:0] q);
        logic r;
        r = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (q[k*4 +: 4] != 4'd0) r = 1'b0;
        end
        return r;
    endfunction

    function automatic logic load_ok(input logic [QW-1:0] d);
        logic r;
        r = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!bcd_digit_ok(d[k*4 +: 4])) r = 1'b0;
        end
        return r;
    endfunction

    // Saturation applies only when the register is already at the end of range.
    function automatic logic sat_hit(input logic up, input logic [QW-1:0] q);
        return SAT_EN && (up ? all_nines(q) : all_zeros(q));
    endfunction

    state_t            state_r, state_nxt;
    logic [IDX_W-1:0]  idx_r, idx_nxt;
    logic              up_r, up_nxt;
    logic [QW-1:0]     q_r, q_nxt;

    logic              done_p0, ovf_p0, err_p0;
    logic              done_p1, ovf_p1, err_p1;

    logic [3:0]        step_digit, step_result;
    logic              step_up, step_carry;

    // One shared decade stepper. In IDLE idx_r is always 0, so the same mux
    // feeds digit 0 for the accept edge and digit idx during the ripple.
    assign step_digit = q_r[int'(idx_r)*4 +: 4];
    assign step_up    = (state_r == ST_IDLE) ? (CMD_OP == OP_UP) : up_r;

    bcd_digit_step u_step (
        .digit  (step_digit),
        .up     (step_up),
        .result (step_result),
        .carry  (step_carry)
    );

    // ------------------------------------------------------------------
    // p0: next-state, next-count and completion flags
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_r;
        idx_nxt   = idx_r;
        up_nxt    = up_r;
        q_nxt     = q_r;
        done_p0   = 1'b0;
        ovf_p0    = 1'b0;
        err_p0    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    case (CMD_OP)
                        OP_CLEAR: begin
                            q_nxt   = '0;
                            done_p0 = 1'b1;
                        end
                        OP_LOAD: begin
                            done_p0 = 1'b1;
                            if (load_ok(D)) q_nxt  = D;
                            else            err_p0 = 1'b1;
                        end
                        default: begin
                            up_nxt = (CMD_OP == OP_UP);
                            if (sat_hit(up_nxt, q_r)) begin
                                done_p0 = 1'b1;
                                ovf_p0  = 1'b1;
                            end else begin
                                q_nxt[3:0] = step_result;
                                if (step_carry && (DIGITS > 1)) begin
                                    state_nxt = ST_RIPPLE;
                                    idx_nxt   = IDX_ONE;
                                end else begin
                                    // single-decade build: carry out of digit 0 is the full wrap
                                    done_p0 = 1'b1;
                                    ovf_p0  = step_carry;
                                end
                            end
                        end
                    endcase
                end
            end

            ST_RIPPLE: begin
                q_nxt[int'(idx_r)*4 +: 4] = step_result;
                if (step_carry && (idx_r != IDX_LAST)) begin
                    idx_nxt = idx_r + IDX_ONE;
                end else begin
                    // carry out of the top decade is the full-range wrap
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    done_p0   = 1'b1;
                    ovf_p0    = step_carry;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // p1: registered state, count and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (MR) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            q_r     <= '0;
            done_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            idx_r   <= idx_nxt;
            q_r     <= q_nxt;
            done_p1 <= done_p0;
            ovf_p1  <= ovf_p0;
            err_p1  <= err_p0;
        end
    end

    // Direction is only consumed in RIPPLE, which is always entered with a
    // freshly written value, so it needs no reset.
    always_ff @(posedge CLK) begin
        up_r <= up_nxt;
    end

    assign Q         = q_r;
    assign CMD_READY = (state_r == ST_IDLE);
    assign BUSY      = (state_r == ST_RIPPLE);
    assign DONE      = done_p1;
    assign OVF       = ovf_p1;
    assign ERR       = err_p1;
    assign TCU       = !all_nines(q_r);
    assign TCD       = !all_zeros(q_r);

endmodule
